// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive sampler.
// Prescale legality, field widths and the 2-of-3 vote live here.
package uart_rx_pkg;

    localparam int PRE_W  = 6;
    localparam int DATA_W = 8;
    localparam int EDGE_W = 5;
    localparam int BIT_W  = 4;
    localparam int SMP_N  = 3;

    localparam logic [PRE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRE_W-1:0] PRESCALE_32 = 6'd32;
    localparam logic [PRE_W-1:0] DEFAULT_PRESCALE = PRESCALE_8;

    localparam logic [PRE_W-1:0]  PRE_ONE  = 6'd1;
    localparam logic [PRE_W-1:0]  PRE_TWO  = 6'd2;
    localparam logic [EDGE_W-1:0] EDGE_ONE = 5'd1;
    localparam logic [BIT_W-1:0]  BIT_ONE  = 4'd1;
    localparam logic [BIT_W-1:0]  BIT_MAX  = 4'd15;

    localparam logic [SMP_N-1:0]  SAMPLE_RST = 3'b111;
    localparam logic [DATA_W-1:0] DATA_RST   = 8'h00;

    // Illegal ratios fall back to the default so the counters
    // always see a power-of-two bit period.
    function automatic logic [PRE_W-1:0] eff_prescale(
        input logic [PRE_W-1:0] p
    );
        logic [PRE_W-1:0] r;
        r = DEFAULT_PRESCALE;
        if (p == PRESCALE_8 || p == PRESCALE_16 ||
            p == PRESCALE_32)
            r = p;
        return r;
    endfunction

    function automatic logic majority3(
        input logic [SMP_N-1:0] s
    );
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Line, control and result bundle between the RX FSM side
// and the oversampling/deserialising block.
interface uart_rx_sampler_if;
    import uart_rx_pkg::*;

    logic              RX_IN;
    logic [PRE_W-1:0]  Prescale;
    logic              enable;
    logic              deser_en;
    logic [EDGE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              sampled_bit;
    logic [DATA_W-1:0] P_DATA;
    logic              bit_done;

    modport master (
        output RX_IN,
        output Prescale,
        output enable,
        output deser_en,
        input  edge_cnt,
        input  bit_cnt,
        input  sampled_bit,
        input  P_DATA,
        input  bit_done
    );

    modport slave (
        input  RX_IN,
        input  Prescale,
        input  enable,
        input  deser_en,
        output edge_cnt,
        output bit_cnt,
        output sampled_bit,
        output P_DATA,
        output bit_done
    );

endinterface

// File: rtl/uart_rx_sampler_counter.sv
// Oversample (edge) and bit position counters for one frame.
// bit_last marks the final oversample of a bit, combinationally.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [PRE_W-1:0]  prescale,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              bit_done,
    output logic              bit_last
);

    logic [PRE_W-1:0] edge_ext;
    logic [PRE_W-1:0] last_idx;

    assign edge_ext = {{(PRE_W-EDGE_W){1'b0}}, edge_cnt};
    assign last_idx = prescale - PRE_ONE;

    // ">=" so a prescale shrink past the current index
    // still closes the bit on the next cycle.
    assign bit_last = enable && (edge_ext >= last_idx);

    // Oversample index: run while framing, wrap at P-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
        end else if (!enable || bit_last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + EDGE_ONE;
        end
    end

    // Bit index: advance on each bit boundary, saturating.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (!enable) begin
            bit_cnt <= '0;
        end else if (bit_last && (bit_cnt != BIT_MAX)) begin
            bit_cnt <= bit_cnt + BIT_ONE;
        end
    end

    // Registered end-of-bit strobe, one cycle wide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_done <= 1'b0;
        end else begin
            bit_done <= bit_last;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: 3-point majority vote around mid-bit
// and LSB-first deserialiser, driven by edge_bit_counter.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    uart_rx_sampler_if.slave bus
);

    logic [PRE_W-1:0]  p_eff;
    logic [PRE_W-1:0]  half;
    logic [PRE_W-1:0]  edge_ext;
    logic [EDGE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_done;
    logic              bit_last;
    logic [SMP_N-1:0]  samples;
    logic              sampled_q;
    logic [DATA_W-1:0] data_q;
    logic              cap0;
    logic              cap1;
    logic              cap2;
    logic              vote;

    assign p_eff    = eff_prescale(bus.Prescale);
    assign half     = p_eff >> 1;
    assign edge_ext = {{(PRE_W-EDGE_W){1'b0}}, edge_cnt};

    // Sample points straddle the bit centre; the vote lands
    // one cycle after the last of them.
    assign cap0 = bus.enable && (edge_ext == half - PRE_ONE);
    assign cap1 = bus.enable && (edge_ext == half);
    assign cap2 = bus.enable && (edge_ext == half + PRE_ONE);
    assign vote = bus.enable && (edge_ext == half + PRE_TWO);

    edge_bit_counter u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (bus.enable),
        .prescale (p_eff),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done),
        .bit_last (bit_last)
    );

    // Capture the line at the three mid-bit oversamples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samples <= SAMPLE_RST;
        end else begin
            if (cap0) samples[0] <= bus.RX_IN;
            if (cap1) samples[1] <= bus.RX_IN;
            if (cap2) samples[2] <= bus.RX_IN;
        end
    end

    // Resolve the bit value by 2-of-3 majority.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sampled_q <= 1'b1;
        end else if (vote) begin
            sampled_q <= majority3(samples);
        end
    end

    // Shift data bits in from the top at each data-bit end.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= DATA_RST;
        end else if (bit_last && bus.deser_en) begin
            data_q <= {sampled_q, data_q[DATA_W-1:1]};
        end
    end

    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.bit_done    = bit_done;
    assign bus.sampled_bit = sampled_q;
    assign bus.P_DATA      = data_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: hand-computed vectors
// for voting, framing, aborts, prescale handling and reset.
module tb_uart_rx_sampler;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;
    int   pulses;

    uart_rx_sampler_if bus ();

    uart_rx_sampler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_edge"}, 32'(bus.edge_cnt), 0);
        check({tag, "_bit"}, 32'(bus.bit_cnt), 0);
        check({tag, "_smp"}, 32'(bus.sampled_bit), 1);
        check({tag, "_data"}, 32'(bus.P_DATA), 32'h00);
        check({tag, "_done"}, 32'(bus.bit_done), 0);
    endtask

    initial begin
        logic [7:0] byte_v;
        vectors     = 0;
        miscompares = 0;
        RST          = 1'b0;
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.enable   = 1'b0;
        bus.deser_en = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #1 RST = 1'b1;
        #1 check_reset("rst_async");
        run(2);
        RST = 1'b0;
        run(3);
        check_reset("rst_release");

        // P=8, one low bit.
        bus.RX_IN  = 1'b0;
        bus.enable = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            pulses += int'(bus.bit_done);
            if (k == 6) begin
                check("p8_e6_edge", 32'(bus.edge_cnt), 6);
                check("p8_e6_smp", 32'(bus.sampled_bit), 1);
            end
            if (k == 7) begin
                check("p8_e7_smp", 32'(bus.sampled_bit), 0);
                check("p8_e7_done", 32'(bus.bit_done), 0);
            end
            if (k == 8) begin
                check("p8_wrap_edge", 32'(bus.edge_cnt), 0);
                check("p8_wrap_bit", 32'(bus.bit_cnt), 1);
                check("p8_wrap_done", 32'(bus.bit_done), 1);
            end
            if (k == 9) check("p8_done_low", 32'(bus.bit_done), 0);
        end
        check("p8_pulses", 32'(pulses), 1);
        bus.enable = 1'b0;
        tick();
        check("dis_edge", 32'(bus.edge_cnt), 0);
        check("dis_bit", 32'(bus.bit_cnt), 0);
        check("dis_smp_hold", 32'(bus.sampled_bit), 0);

        // P=16 frame carrying 8'hA5.
        byte_v       = 8'hA5;
        bus.Prescale = 6'd16;
        bus.RX_IN    = 1'b0;
        bus.enable   = 1'b1;
        run(16);
        check("a5_start_bit", 32'(bus.bit_cnt), 1);
        for (int b = 0; b < 8; b++) begin
            bus.RX_IN    = byte_v[b];
            bus.deser_en = 1'b1;
            run(14);
            if (b == 2)
                check("a5_smp_chk", 32'(bus.sampled_bit), 1);
            run(2);
            if (b == 3)
                check("a5_half", 32'(bus.P_DATA), 32'h50);
        end
        bus.deser_en = 1'b0;
        check("a5_data", 32'(bus.P_DATA), 32'hA5);
        check("a5_bitcnt", 32'(bus.bit_cnt), 9);
        check("a5_done", 32'(bus.bit_done), 1);

        // Single-sample glitch is outvoted.
        bus.RX_IN = 1'b1;
        run(8);
        bus.RX_IN = 1'b0;
        tick();
        bus.RX_IN = 1'b1;
        run(5);
        check("glitch1_smp", 32'(bus.sampled_bit), 1);
        run(2);
        // Two low samples win the vote.
        run(8);
        bus.RX_IN = 1'b0;
        run(2);
        bus.RX_IN = 1'b1;
        run(4);
        check("glitch2_smp", 32'(bus.sampled_bit), 0);
        run(2);
        check("glitch2_bitcnt", 32'(bus.bit_cnt), 11);
        bus.enable = 1'b0;
        tick();

        // P=32, abort at edge 20 of bit 3.
        bus.Prescale = 6'd32;
        bus.RX_IN    = 1'b0;
        bus.enable   = 1'b1;
        run(96);
        check("p32_bit3", 32'(bus.bit_cnt), 3);
        bus.deser_en = 1'b1;
        run(20);
        check("p32_e20", 32'(bus.edge_cnt), 20);
        bus.enable = 1'b0;
        tick();
        check("abort_edge", 32'(bus.edge_cnt), 0);
        check("abort_bit", 32'(bus.bit_cnt), 0);
        check("abort_done", 32'(bus.bit_done), 0);
        check("abort_data", 32'(bus.P_DATA), 32'hA5);

        // deser_en alone does nothing.
        run(40);
        check("deser_only_data", 32'(bus.P_DATA), 32'hA5);
        check("deser_only_edge", 32'(bus.edge_cnt), 0);
        bus.deser_en = 1'b0;

        // Illegal prescale behaves as 8.
        bus.Prescale = 6'd12;
        bus.RX_IN    = 1'b1;
        bus.enable   = 1'b1;
        run(7);
        check("p12_e7", 32'(bus.edge_cnt), 7);
        check("p12_smp", 32'(bus.sampled_bit), 1);
        tick();
        check("p12_wrap", 32'(bus.edge_cnt), 0);
        check("p12_bit", 32'(bus.bit_cnt), 1);
        check("p12_done", 32'(bus.bit_done), 1);
        bus.enable = 1'b0;
        tick();

        // Prescale shrink past the current index closes the bit.
        bus.Prescale = 6'd32;
        bus.enable   = 1'b1;
        run(20);
        bus.Prescale = 6'd16;
        tick();
        check("shrink_edge", 32'(bus.edge_cnt), 0);
        check("shrink_bit", 32'(bus.bit_cnt), 1);
        check("shrink_done", 32'(bus.bit_done), 1);
        bus.enable = 1'b0;
        tick();

        // bit_cnt saturates at 15.
        bus.Prescale = 6'd8;
        bus.enable   = 1'b1;
        run(8 * 17);
        check("bit_sat", 32'(bus.bit_cnt), 15);
        bus.enable = 1'b0;
        tick();

        // Reset mid-frame at bit 5, P_DATA partly refilled.
        bus.RX_IN  = 1'b0;
        bus.enable = 1'b1;
        run(8);
        bus.RX_IN    = 1'b1;
        bus.deser_en = 1'b1;
        run(32);
        bus.deser_en = 1'b0;
        run(3);
        check("mid_bit5", 32'(bus.bit_cnt), 5);
        check("mid_data", 32'(bus.P_DATA), 32'hFA);
        #2 RST = 1'b1;
        #1 check_reset("rst_mid");
        bus.enable = 1'b0;
        tick();
        RST = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(bus.bit_done);
        end
        check("rel_no_done", 32'(pulses), 0);
        check("rel_edge", 32'(bus.edge_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
